// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and helpers for the bit-serial adder unit.
// Optional build macro used by seq_adder_unit: SEQ_ADDER_SAT_EN.
package seq_adder_pkg;

    // Operation select, encoded as driven on the mode port
    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit counter must be able to hold the value WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_adder_full_adder.sv
// full_adder_cell: one-bit full adder built from two half-adder stages.
// The second stage adds the carry-in to the first stage's partial sum;
// at most one of the two stages can generate a carry, so OR merges them.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: a + b
    assign w_s1   = i_a ^ i_b;
    assign w_c1   = i_a & i_b;

    // Second half adder: partial sum + carry-in
    assign o_sum  = w_s1 ^ i_cin;
    assign w_c2   = w_s1 & i_cin;

    assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/seq_adder_unit.sv
// seq_adder_unit: bit-serial add/sub/accumulate, one bit per enabled clock.
// Operands are shifted LSB first through a single full_adder_cell; the
// result register fills from the MSB side. Define SEQ_ADDER_SAT_EN to get
// unsigned saturation of the written result (flags stay raw).
module seq_adder_unit
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int CW = cnt_width(WIDTH);

    state_e           r_state;
    state_e           w_next;
    mode_e            r_mode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Holds the first WIDTH-1 sum bits; the final bit comes straight
    // from the adder on the last bit-edge.
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_final;
    logic             w_ovf_raw;

    assign w_accept  = (r_state == ST_IDLE) && start && ena;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_res     = {w_s, r_res};
    // On the last bit-edge r_carry is the carry into the MSB.
    assign w_ovf_raw = r_carry ^ w_c;

    full_adder_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

`ifdef SEQ_ADDER_SAT_EN
    // Clamp to the unsigned range: overflow -> all ones, borrow -> zero
    always_comb begin
        w_final = w_res;
        if (r_mode == MODE_SUB) begin
            if (!w_c) w_final = '0;
        end else begin
            if (w_c) w_final = '1;
        end
    end
`else
    assign w_final = w_res;
`endif

    // State register; w_next already folds in ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)
                         w_next = (mode_e'(mode) == MODE_CLR) ? ST_DONE : ST_RUN;
            ST_RUN:  if (ena && w_last) w_next = ST_DONE;
            ST_DONE: if (ena) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state; done holds while ena is low
    always_comb begin
        ready = (r_state == ST_IDLE);
        busy  = (r_state == ST_RUN);
        done  = (r_state == ST_DONE);
    end

    // Operand capture, bit-serial datapath and result/accumulator writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_acc   <= '0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_mode <= mode_e'(mode);
                    r_cnt  <= '0;
                    case (mode_e'(mode))
                        MODE_ADD: begin
                            r_a     <= op_a;
                            r_b     <= op_b;
                            r_carry <= 1'b0;
                        end
                        MODE_SUB: begin
                            // a - b computed as a + ~b + 1
                            r_a     <= op_a;
                            r_b     <= ~op_b;
                            r_carry <= 1'b1;
                        end
                        MODE_ACC: begin
                            r_a     <= r_acc;
                            r_b     <= op_a;
                            r_carry <= 1'b0;
                        end
                        MODE_CLR: begin
                            r_acc  <= '0;
                            r_sum  <= '0;
                            r_cout <= 1'b0;
                            r_ovf  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res[WIDTH-1:1];
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Last bit-edge is also the DONE entry edge
                    if (w_last) begin
                        r_sum  <= w_final;
                        r_cout <= w_c;
                        r_ovf  <= w_ovf_raw;
                        if (r_mode == MODE_ACC) r_acc <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign ovf       = r_ovf;
    assign acc       = r_acc;

endmodule

// File: tb/tb_seq_adder_unit.sv
// tb_seq_adder_unit: scoreboard bench for seq_adder_unit (WIDTH=8).
// Expected results come from an integer-arithmetic model of the operations.
module tb_seq_adder_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         ready, busy, done, carry_out, ovf;
    logic [W-1:0] sum, acc;

    seq_adder_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
        .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
        .sum(sum), .carry_out(carry_out), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic ena_at_edge = 1'b1;
    always @(posedge clk) ena_at_edge <= ena;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W-1:0] acc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_acc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return (int'(v) >= 2 ** (W - 1)) ? int'(v) - 2 ** W : int'(v);
    endfunction

    // Reference model: plain integer arithmetic on the operation's meaning
    function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] cur_acc);
        exp_t e;
        int   r, sr;
        logic [W-1:0] x, y;
        x = (md == 2'b10) ? cur_acc : a;
        y = (md == 2'b10) ? a : b;
        if (md == 2'b11) begin
            e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0; e.acc = '0;
            return e;
        end
        if (md == 2'b01) begin
            r      = int'(x) - int'(y);
            sr     = sx(x) - sx(y);
            e.cout = (int'(x) >= int'(y));
        end else begin
            r      = int'(x) + int'(y);
            sr     = sx(x) + sx(y);
            e.cout = (r >= 2 ** W);
        end
        e.sum = W'(r & (2 ** W - 1));
        e.ovf = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
`ifdef SEQ_ADDER_SAT_EN
        if (md == 2'b01 && !e.cout) e.sum = '0;
        if (md != 2'b01 && e.cout)  e.sum = '1;
`endif
        e.acc = (md == 2'b10) ? e.sum : cur_acc;
        return e;
    endfunction

    // Monitor: pops and compares on each rising done
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_width", {31'd0, prev_done && ena_at_edge}, 32'd0);
                if (!prev_done) begin
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        chk("sum", sum, e.sum);
                        chk("carry_out", carry_out, e.cout);
                        chk("ovf", ovf, e.ovf);
                        chk("acc", acc, e.acc);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_cout"}, carry_out, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_acc"}, acc, 0);
    endtask

    // Issue one op; optionally poke start during RUN or stall with ena=0
    task automatic do_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input bit poke);
        exp_t e;
        int   t0, k, exp_cyc;
        logic [3*W+5:0] snap;
        @(negedge clk);
        k = 0;
        while (!ready && k < 100) begin @(negedge clk); k++; end
        if (!ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
            return;
        end
        e = model(md, a, b, m_acc);
        m_acc = e.acc;
        q.push_back(e);
        start = 1'b1; mode = md; op_a = a; op_b = b;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        // Changes after acceptance must have no effect
        mode = 2'($urandom); op_a = W'($urandom); op_b = W'($urandom);
        k = 0;
        while (!done && k < 200) begin
            if (poke && k == 2) begin start = 1'b1; mode = 2'b11; end
            if (poke && k == 3) start = 1'b0;
            if (stall > 0 && k == 3) begin
                ena  = 1'b0;
                snap = {sum, acc, carry_out, ovf, ready, busy, done, 1'b0, W'(0)};
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("stall_hold", 32'({sum, acc, carry_out, ovf, ready, busy, done}),
                        32'(snap[3*W+5:W+1]));
                end
                ena = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got done=0 expected 1");
            q.delete();
            return;
        end
        exp_cyc = (md == 2'b11) ? t0 + 1 : t0 + W + 1 + stall;
        chk("latency", cyc, exp_cyc);
        @(negedge clk);
        chk("ready_after", ready, 1);
        chk("done_dropped", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        do_op(2'b00, 8'h5A, 8'h33, 0, 0);
        do_op(2'b00, 8'hFF, 8'h01, 0, 0);
        do_op(2'b01, 8'h10, 8'h20, 0, 0);
        do_op(2'b01, 8'h80, 8'h01, 0, 0);
        do_op(2'b11, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) do_op(2'b10, 8'h40, 8'h00, 0, 0);
        do_op(2'b00, 8'h21, 8'h43, 0, 1);
        do_op(2'b00, 8'h12, 8'h34, 5, 0);

        // Reset in the middle of an ADD, after three bit-edges
        @(negedge clk);
        start = 1'b1; mode = 2'b00; op_a = 8'h77; op_b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        q.delete();
        m_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 8'h12, 8'h34, 0, 0);

        for (int i = 0; i < 30; i++)
            do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
